linked_fifo_pop_sched: RTL
==========================

# linked_fifo_pop_sched

Pop-side scheduler for the shared-RAM `linked_fifo`. It tracks per-queue occupancy by snooping accepted pushes and holds per-queue downstream credits. Each cycle it picks one eligible logical queue round-robin and drives `pop`/`pop_fifo`. It then returns the popped word, tagged with its queue id, after the fifo's read latency.

## Interface
Parameters:
- `QUEUES`, 8: number of logical fifos (power of two).
- `QID_W`, 3: log2(QUEUES).
- `WIDTH`, 8: data width.
- `CNT_W`, 7: occupancy counter width; must hold total RAM depth (64).
- `CREDITS`, 4: initial and maximum downstream credits per queue.
- `CRD_W`, 3: credit counter width; must hold CREDITS.
- `Q_LATENCY`, 1: cycles from pop sampled by the fifo to valid `fifo_q`; ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scheduling enable; low blocks new pops, in-flight pops complete.
- `snoop_push`  in  1  push accepted by the fifo this cycle (already qualified with !full).
- `snoop_push_fifo`  in  QID_W  queue of snooped push.
- `credit_ret`  in  1  downstream returns one credit.
- `credit_qid`  in  QID_W  queue receiving the credit.
- `fifo_q`  in  WIDTH  fifo read data.
- `pop`  out  1  registered pop to fifo.
- `pop_fifo`  out  QID_W  registered queue select to fifo.
- `out_valid`  out  1  one-cycle pulse, popped word available.
- `out_queue`  out  QID_W  queue id of `out_data`.
- `out_data`  out  WIDTH  popped word.
- `error`  out  1  sticky consistency error (see Configuration).

## Operation
- State per queue: `occ[i]` (CNT_W bits) and `crd[i]` (CRD_W bits). The scheduler also holds an RR pointer `last` (QID_W bits).
- Eligible(i) = `en` && `occ[i]` != 0 && `crd[i]` != 0, evaluated on registered state only.
- Grant: the first eligible queue searching `last+1`, `last+2`, …, wrapping modulo QUEUES. On grant g at edge E:
  - `pop`=1 and `pop_fifo`=g for the cycle after E.
  - `occ[g]`−1, `crd[g]`−1, `last`=g.
- With no eligible queue: `pop`=0, `pop_fifo` holds its previous value, `last` is unchanged.
- At most one pop per cycle. A queue may be granted on consecutive cycles if it is the only eligible queue.
- Snooped push on q: `occ[q]`+1. Credit return on q: `crd[q]`+1, saturating at CREDITS.
- Simultaneous events on the same queue in the same cycle:
  - grant + push: `occ` unchanged.
  - grant + credit return: `crd` unchanged.
  - All three: both counters unchanged.
- Return path:
  - A QID_W+1-bit delay line of depth Q_LATENCY carries {pop, pop_fifo}.
  - When the delayed pop emerges, `out_data`<=`fifo_q`, `out_queue`<=the delayed id, `out_valid`<=1. Otherwise `out_valid`<=0, and `out_data`/`out_queue` hold.
- No output backpressure; credits are the only flow control.
- Reset (any cycle, including mid-operation) has priority over all other inputs and sets:
  - `occ`=0, `crd`=CREDITS, `last`=QUEUES−1 (first grant goes to queue 0).
  - `pop`=0, `pop_fifo`=0, delay line cleared, `out_valid`=0, `out_queue`=0, `out_data`=0, `error`=0.
- In-flight pops are discarded on reset; the fifo must be reset together with this block.

## Timing
- Push accepted at edge E0 → `occ` is 1 after E0 → earliest grant at E1 → `pop` high in cycle E1..E2.
- `pop` sampled by the fifo at E2 → `fifo_q` valid Q_LATENCY cycles later → `out_valid` is registered on the following edge.
- Pop-to-`out_valid` latency: Q_LATENCY+1 cycles after the pop cycle.
- Sustained throughput: 1 pop/cycle while any queue is eligible.
- `en` falling at edge E: no grant at E or later; up to Q_LATENCY+1 subsequent `out_valid` pulses still drain.

## Configuration
- `LINKED_FIFO_SCHED_CHECK_EN` defined: `error` sets and stays set until reset on any of:
  - snooped push to a queue with `occ` at 2^CNT_W−1,
  - credit return to a queue whose `crd` is already CREDITS,
  - `fifo_q` delay-line output colliding with reset-in-progress (impossible by construction; asserted for bench).
- Undefined: checking logic removed, `error` tied 0, and counters wrap/saturate as above without reporting.

## Test plan
- Reset then push 2 words to queue 0 (d=5,6), `en`=1 → pops of q0 on consecutive cycles; `out_data` 5 then 6, `out_queue`=0, `occ[0]`=0.
- One push each to queues 1, 3, 7 in the same idle period → grant order 1, 3, 7; `out_queue` sequence 1, 3, 7; `last`=7 afterwards.
- 6 pushes to queue 2 with no credit returns → exactly 4 pops (CREDITS); 1 credit return → exactly 1 more pop; `occ[2]`=1.
- Push to queue 4 in the same cycle as its grant with `occ[4]`=1 → `occ[4]` remains 1 and a second pop follows the next cycle.
- `en` low with all queues occupied → `pop`=0 indefinitely; pulse `rst` while 2 pops are in flight → `out_valid`=0 and all outputs at reset values the next cycle.
- With `LINKED_FIFO_SCHED_CHECK_EN`: credit return to queue 5 at `crd`=4 → `error`=1 the next cycle and sticky until `rst`.

Source files
------------

// File: rtl/linked_fifo_pop_sched.sv
// linked_fifo_pop_sched
// Pop-side scheduler for the shared-RAM linked_fifo. It tracks per-queue
// occupancy by snooping accepted pushes and holds per-queue downstream
// credits. Each cycle it grants one eligible queue in round-robin order and
// drives pop/pop_fifo. The popped word comes back tagged with its queue id
// after the fifo read latency.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   en                scheduling enable; in-flight pops still complete
//   snoop_push(_fifo) push accepted by the fifo and its queue
//   credit_ret/qid    downstream credit return and its queue
//   fifo_q            fifo read data
//   pop, pop_fifo     registered pop request and queue select to the fifo
//   out_valid/queue/data  one-cycle pulse with the popped word and its queue
//   error             sticky consistency error
//
// Optional feature: define LINKED_FIFO_SCHED_CHECK_EN to enable the overflow
// and credit-overrun checks driving error; otherwise error is tied low.
module linked_fifo_pop_sched #(
  parameter int QUEUES    = 8,
  parameter int QID_W     = 3,
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 7,
  parameter int CREDITS   = 4,
  parameter int CRD_W     = 3,
  parameter int Q_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             snoop_push,
  input  logic [QID_W-1:0] snoop_push_fifo,
  input  logic             credit_ret,
  input  logic [QID_W-1:0] credit_qid,
  input  logic [WIDTH-1:0] fifo_q,
  output logic             pop,
  output logic [QID_W-1:0] pop_fifo,
  output logic             out_valid,
  output logic [QID_W-1:0] out_queue,
  output logic [WIDTH-1:0] out_data,
  output logic             error
);

  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

  logic [CNT_W-1:0] occ_r [QUEUES];
  logic [CRD_W-1:0] crd_r [QUEUES];
  logic [QID_W-1:0] last_r;
  logic [QID_W:0]   dly_r [Q_LATENCY];

  logic [QUEUES-1:0] elig_s;
  logic [QUEUES-1:0] dec_s;
  logic [QUEUES-1:0] inc_s;
  logic [QUEUES-1:0] ret_s;
  logic              grant_s;
  logic [QID_W-1:0]  grant_q_s;
  logic [QID_W-1:0]  idx_s;

  // Per-queue eligibility and decoded push/credit/grant events.
  always_comb begin
    for (int i = 0; i < QUEUES; i++) begin
      elig_s[i] = en && (occ_r[i] != {CNT_W{1'b0}}) && (crd_r[i] != {CRD_W{1'b0}});
      inc_s[i]  = snoop_push && (snoop_push_fifo == QID_W'(i));
      ret_s[i]  = credit_ret && (credit_qid == QID_W'(i));
      dec_s[i]  = grant_s && (grant_q_s == QID_W'(i));
    end
  end

  // Round-robin search starting just after the last granted queue; the final
  // iteration (offset QUEUES) wraps back onto last_r itself.
  always_comb begin
    grant_s   = 1'b0;
    grant_q_s = last_r;
    idx_s     = last_r;
    for (int i = 1; i <= QUEUES; i++) begin
      idx_s = last_r + QID_W'(i);
      if (!grant_s && elig_s[idx_s]) begin
        grant_s   = 1'b1;
        grant_q_s = idx_s;
      end else begin
        grant_s   = grant_s;
      end
    end
  end

  // Occupancy/credit counters, RR pointer and the registered pop request.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUES; i++) begin
        occ_r[i] <= {CNT_W{1'b0}};
        crd_r[i] <= CRD_MAX;
      end
      last_r   <= QID_W'(QUEUES - 1);
      pop      <= 1'b0;
      pop_fifo <= {QID_W{1'b0}};
    end else begin
      for (int i = 0; i < QUEUES; i++) begin
        // A grant and a push on the same queue cancel each other.
        case ({inc_s[i], dec_s[i]})
          2'b10:   occ_r[i] <= occ_r[i] + CNT_W'(1);
          2'b01:   occ_r[i] <= occ_r[i] - CNT_W'(1);
          default: occ_r[i] <= occ_r[i];
        endcase
        // Credit returns saturate at CREDITS; grant + return cancel.
        case ({ret_s[i], dec_s[i]})
          2'b10: begin
            if (crd_r[i] != CRD_MAX) begin
              crd_r[i] <= crd_r[i] + CRD_W'(1);
            end else begin
              crd_r[i] <= crd_r[i];
            end
          end
          2'b01:   crd_r[i] <= crd_r[i] - CRD_W'(1);
          default: crd_r[i] <= crd_r[i];
        endcase
      end
      pop <= grant_s;
      if (grant_s) begin
        last_r   <= grant_q_s;
        pop_fifo <= grant_q_s;
      end else begin
        last_r   <= last_r;
        pop_fifo <= pop_fifo;
      end
    end
  end

  // Delay line matching the fifo read latency; carries {pop, pop_fifo}.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Q_LATENCY; i++) begin
        dly_r[i] <= {(QID_W + 1){1'b0}};
      end
    end else begin
      dly_r[0] <= {pop, pop_fifo};
      for (int i = 1; i < Q_LATENCY; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

  // Capture the returned word when the delayed pop emerges.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_queue <= {QID_W{1'b0}};
      out_data  <= {WIDTH{1'b0}};
    end else if (dly_r[Q_LATENCY-1][QID_W]) begin
      out_valid <= 1'b1;
      out_queue <= dly_r[Q_LATENCY-1][QID_W-1:0];
      out_data  <= fifo_q;
    end else begin
      out_valid <= 1'b0;
      out_queue <= out_queue;
      out_data  <= out_data;
    end
  end

`ifdef LINKED_FIFO_SCHED_CHECK_EN
  logic err_set_s;

  // Push into a full counter or credit return beyond CREDITS. A delay-line
  // word meeting reset cannot be seen here: reset clears both in one edge.
  always_comb begin
    err_set_s = 1'b0;
    for (int i = 0; i < QUEUES; i++) begin
      if ((inc_s[i] && (occ_r[i] == {CNT_W{1'b1}})) ||
          (ret_s[i] && (crd_r[i] == CRD_MAX))) begin
        err_set_s = 1'b1;
      end else begin
        err_set_s = err_set_s;
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      error <= 1'b0;
    end else if (err_set_s) begin
      error <= 1'b1;
    end else begin
      error <= error;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
